// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one 64-bit shifter with a registered, tagged response
module shift_unit_arbiter #(
  parameter int XLEN = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req0_word,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  input  logic               req1_word,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [XLEN-1:0]    resp_data,
  output logic               resp_err
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;
  logic last_grant_q, resp_id_q, resp_err_q;
  logic [XLEN-1:0] resp_data_q;
  logic grant, slot_free, fire;
  logic [XLEN-1:0] op_data, sll64, srl64, sra64, res64, shift_res;
  logic [SHAMT_W-1:0] op_shamt;
  logic [1:0] op_op;
  logic op_word;
  logic [31:0] sll32, srl32, sra32, res32;
  assign grant = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign slot_free = (state_q == EMPTY) | resp_ready;
  assign req0_ready = slot_free & ~grant & ~rst;
  assign req1_ready = slot_free & grant & ~rst;
  assign fire = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign resp_valid = state_q == FULL;
  assign resp_id = resp_id_q;
  assign resp_data = resp_data_q;
  assign resp_err = resp_err_q;
  // steer the granted payload through the shifter; W-forms sign-extend their 32-bit result
  always_comb begin
    op_data = grant ? req1_data : req0_data;
    op_shamt = grant ? req1_shamt : req0_shamt;
    op_op = grant ? req1_op : req0_op;
    op_word = grant ? req1_word : req0_word;
    sll64 = op_data << op_shamt;
    srl64 = op_data >> op_shamt;
    sra64 = $signed(op_data) >>> op_shamt;
    sll32 = op_data[31:0] << op_shamt[4:0];
    srl32 = op_data[31:0] >> op_shamt[4:0];
    sra32 = $signed(op_data[31:0]) >>> op_shamt[4:0];
    res64 = (op_op == 2'b00) ? sll64 : (op_op == 2'b01) ? srl64 : sra64;
    res32 = (op_op == 2'b00) ? sll32 : (op_op == 2'b01) ? srl32 : sra32;
    shift_res = (op_op == 2'b11) ? '0 : op_word ? {{(XLEN-32){res32[31]}}, res32} : res64;
  end
  // output slot fills on fire, empties on drain without a replacement, otherwise holds
  always_comb begin
    state_d = fire ? FULL : resp_ready ? EMPTY : state_q;
  end
  // state register; reset discards any held result
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // result register and round-robin pointer load only when an operation fires
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      resp_id_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q <= 1'b0;
    end else if (fire) begin
      last_grant_q <= grant;
      resp_id_q <= grant;
      resp_data_q <= shift_res;
      resp_err_q <= &op_op;
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: scoreboard bench for the shared shifter arbiter
module tb_shift_unit_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req0_ready, req0_word = 1'b0;
  logic req1_valid = 1'b0, req1_ready, req1_word = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0, resp_data;
  logic [5:0] req0_shamt = '0, req1_shamt = '0;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic resp_valid, resp_ready = 1'b1, resp_id, resp_err;
  typedef struct packed {logic id; logic [63:0] data; logic err;} rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  int checks = 0, failures = 0;
  logic lg_m = 1'b1;

  shift_unit_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op), .req0_word(req0_word),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op), .req1_word(req1_word),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] model(logic [1:0] op, logic [63:0] d, logic [5:0] s, logic w);
    logic [63:0] r;
    logic [31:0] x;
    r = d;
    x = d[31:0];
    if (op == 2'b11) return {1'b1, 64'd0};
    for (int i = 0; i < (w ? int'(s[4:0]) : int'(s)); i++) begin
      r = (op == 2'b00) ? {r[62:0], 1'b0} : {(op == 2'b10) & r[63], r[63:1]};
      x = (op == 2'b00) ? {x[30:0], 1'b0} : {(op == 2'b10) & x[31], x[31:1]};
    end
    return {1'b0, w ? {{32{x[31]}}, x} : r};
  endfunction

  task automatic drive(input int n, input logic [1:0] op, input logic [63:0] d, input logic [5:0] s, input logic w);
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_data = d; req0_shamt = s; req0_word = w;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_data = d; req1_shamt = s; req1_word = w;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic push(input logic id, input logic [63:0] d, input logic err);
    exp_q.push_back('{id, d, err});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    lg_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp_valid, resp_id, resp_data, resp_err} !== 67'd0) begin
      failures++; $display("FAIL reset_state got v=%b id=%b d=%h e=%b exp all zero", resp_valid, resp_id, resp_data, resp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    lg_m = 1'b1;
  endtask

  task automatic test_sra();
    resp_ready = 1'b1;
    drive(0, 2'b10, 64'h8000_0000_0000_0000, 6'd63, 1'b0);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL sra_ready got=%b exp=1", req0_ready);
    end
    push(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    lg_m = 1'b0;
    @(posedge clk); #1;
    idle();
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL sra_resp got v=%b id=%b d=%h e=%b exp id=%b d=%h e=%b", resp_valid, resp_id, resp_data, resp_err, e.id, e.data, e.err);
    end
  endtask

  task automatic test_fairness();
    logic g;
    do_reset();
    resp_ready = 1'b1;
    drive(0, 2'b00, 64'h1, 6'd4, 1'b0);
    drive(1, 2'b01, 64'h100, 6'd4, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = ~lg_m;
      checks++;
      if ({req0_ready, req1_ready} !== {~g, g}) begin
        failures++; $display("FAIL fair_grant%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {~g, g});
      end
      push(g, 64'h10, 1'b0);
      lg_m = g;
      @(posedge clk); #1;
      checks++;
      e = exp_q.pop_front();
      if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
        failures++; $display("FAIL fair_resp%0d got v=%b id=%b d=%h exp id=%b d=%h", k, resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 2'b00, 64'hA, 6'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL bp_first_ready got=%b exp=1", req0_ready);
    end
    push(1'b0, 64'h14, 1'b0);
    lg_m = 1'b0;
    @(posedge clk); #1;
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL bp_first_resp got v=%b id=%b d=%h exp id=%b d=%h", resp_valid, resp_id, resp_data, e.id, e.data);
    end
    resp_ready = 1'b0;
    drive(0, 2'b00, 64'h3, 6'd2, 1'b0);
    drive(1, 2'b10, 64'hFF00_0000_0000_0000, 6'd8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, resp_data} !== {2'b00, 1'b1, 1'b0, 64'h14}) begin
        failures++; $display("FAIL bp_hold%0d got rdy=%b v=%b id=%b d=%h exp rdy=00 v=1 id=0 d=14", k, {req0_ready, req1_ready}, resp_valid, resp_id, resp_data);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    push(1'b1, 64'hFFFF_0000_0000_0000, 1'b0);
    lg_m = 1'b1;
    @(posedge clk); #1;
    idle();
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL bp_release_resp got v=%b id=%b d=%h exp id=%b d=%h", resp_valid, resp_id, resp_data, e.id, e.data);
    end
  endtask

  task automatic test_word();
    logic [1:0] ops[4] = '{2'b00, 2'b01, 2'b10, 2'b01};
    logic [63:0] ds[4] = '{64'h1, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000};
    logic [5:0] ss[4] = '{6'd31, 6'h20, 6'd4, 6'd1};
    logic [63:0] xs[4] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F800_0000, 64'h0000_0000_4000_0000};
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, ops[k], ds[k], ss[k], 1'b1);
      @(negedge clk);
      checks++;
      if (req0_ready !== 1'b1) begin
        failures++; $display("FAIL word_ready%0d got=%b exp=1", k, req0_ready);
      end
      push(1'b0, xs[k], 1'b0);
      lg_m = 1'b0;
      @(posedge clk); #1;
      checks++;
      e = exp_q.pop_front();
      if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
        failures++; $display("FAIL word_resp%0d got v=%b d=%h e=%b exp d=%h", k, resp_valid, resp_data, resp_err, e.data);
      end
    end
    idle();
  endtask

  task automatic test_illegal();
    drive(1, 2'b11, 64'h1234, 6'd0, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("FAIL illegal_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    push(1'b1, 64'd0, 1'b1);
    lg_m = 1'b1;
    @(posedge clk); #1;
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL illegal_resp got v=%b id=%b d=%h e=%b exp id=1 d=0 e=1", resp_valid, resp_id, resp_data, resp_err);
    end
    drive(0, 2'b01, 64'hF0, 6'd4, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL illegal_next_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    push(1'b0, 64'hF, 1'b0);
    lg_m = 1'b0;
    @(posedge clk); #1;
    idle();
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL illegal_next_resp got v=%b id=%b d=%h e=%b exp id=0 d=f e=0", resp_valid, resp_id, resp_data, resp_err);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 2'b00, 64'h1, 6'd1, 1'b0);
    @(negedge clk);
    push(1'b0, 64'h2, 1'b0);
    @(posedge clk); #1;
    idle();
    resp_ready = 1'b0;
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL rstmid_pre got v=%b d=%h exp v=1 d=2", resp_valid, resp_data);
    end
    rst = 1'b1;
    drive(0, 2'b00, 64'h5, 6'd0, 1'b0);
    drive(1, 2'b00, 64'h6, 6'd0, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL rstmid_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    lg_m = 1'b1;
    idle();
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_dropped got v=%b exp=0", resp_valid);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_reappear got v=%b exp=0", resp_valid);
    end
    drive(0, 2'b01, 64'h80, 6'd3, 1'b0);
    drive(1, 2'b00, 64'h1, 6'd9, 1'b0);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rstmid_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    push(1'b0, 64'h10, 1'b0);
    lg_m = 1'b0;
    @(posedge clk); #1;
    idle();
    checks++;
    e = exp_q.pop_front();
    if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, e}) begin
      failures++; $display("FAIL rstmid_after got v=%b id=%b d=%h exp id=0 d=10", resp_valid, resp_id, resp_data);
    end
  endtask

  task automatic test_random();
    logic full, pend, sf, g, f;
    logic [64:0] m;
    do_reset();
    full = 1'b0;
    pend = 1'b0;
    for (int k = 0; k < 300; k++) begin
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      resp_ready = $urandom_range(0, 3) != 0;
      req0_op = 2'($urandom_range(0, 3)); req1_op = 2'($urandom_range(0, 3));
      req0_data = {$urandom, $urandom}; req1_data = {$urandom, $urandom};
      req0_shamt = 6'($urandom_range(0, 63)); req1_shamt = 6'($urandom_range(0, 63));
      req0_word = 1'($urandom_range(0, 1)); req1_word = 1'($urandom_range(0, 1));
      @(negedge clk);
      sf = ~full | resp_ready;
      g = (req0_valid & req1_valid) ? ~lg_m : req1_valid;
      checks++;
      if ({req0_ready, req1_ready} !== {sf & ~g, sf & g}) begin
        failures++; $display("FAIL rand_ready%0d got=%b exp=%b", k, {req0_ready, req1_ready}, {sf & ~g, sf & g});
      end
      f = sf & (g ? req1_valid : req0_valid);
      if (f) begin
        m = g ? model(req1_op, req1_data, req1_shamt, req1_word) : model(req0_op, req0_data, req0_shamt, req0_word);
        push(g, m[63:0], m[64]);
        lg_m = g;
      end
      pend = f;
      full = f | (full & ~resp_ready);
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== full) begin
        failures++; $display("FAIL rand_valid%0d got=%b exp=%b", k, resp_valid, full);
      end
      if (pend) begin
        checks++;
        e = exp_q.pop_front();
        if ({resp_id, resp_data, resp_err} !== e) begin
          failures++; $display("FAIL rand_resp%0d got id=%b d=%h e=%b exp id=%b d=%h e=%b", k, resp_id, resp_data, resp_err, e.id, e.data, e.err);
        end
      end
    end
    idle();
    resp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sra();
    test_fairness();
    test_backpressure();
    test_word();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
Shares one 64-bit shift datapath (SLL/SRL/SRA, RV64 word variants) between two requesters, e.g. the EX-stage ALU and the address/multiply-divide helper. Uses round-robin arbitration and valid/ready handshakes on every port. Produces one registered result per cycle on a single tagged response channel with backpressure.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
SHAMT_W, 6, shift-amount width; equals log2(XLEN).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; synchronous, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_data  input  64  operand
req0_shamt  input  6  shift amount
req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal
req0_word  input  1  1 = 32-bit W-form operation
req1_valid, req1_ready, req1_data, req1_shamt, req1_op, req1_word: same as requester 0, for requester 1
resp_valid  output  1  result register holds a valid result
resp_ready  input  1  consumer takes the result
resp_id  output  1  requester that issued the result
resp_data  output  64  shift result
resp_err  output  1  op was illegal (11)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: resp_valid=0, resp_id=0, resp_data=0, resp_err=0, last_grant=1. req0_ready and req1_ready are 0 during any cycle with rst=1.
- slot_free = !resp_valid | resp_ready. No grant is made unless slot_free.
- Arbitration (combinational, same cycle):
  - Exactly one reqN_valid: grant N.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = slot_free & grant==N & !rst. reqN_ready may depend on either valid input.
- Fire: reqN_valid & reqN_ready. At most one fire per cycle. last_grant updates to N only on fire.
- Latency: 1 cycle. The fired operation's result, id and err load into the output register at the next edge, and resp_valid=1.
- Output register state:
  - Drain without fire: resp_valid goes to 0.
  - Drain and fire in the same cycle: the new result replaces the old one. Sustained throughput is 1 op per cycle.
- State machine:
  - EMPTY (resp_valid=0) -> FULL on fire.
  - FULL -> FULL on drain+fire, or while holding (resp_ready=0).
  - FULL -> EMPTY on drain without fire.
- While FULL and resp_ready=0, resp_id, resp_data and resp_err are held bit-stable.
- Shift rules, non-word:
  - Shift amount is shamt[5:0].
  - SLL zero-fills.
  - SRL zero-fills.
  - SRA fills with data[63].
- Shift rules, word (word=1):
  - Operand is data[31:0]; shift amount is shamt[4:0]; shamt[5] is ignored.
  - The 32-bit result is sign-extended from its bit 31 into [63:32], for all three ops.
  - SRAW fills with data[31].
- Illegal op (11): resp_data=0, resp_err=1. The op is still handshaken and still counts for last_grant.
- Protocol: a requester holds valid and payload stable until fire. The block does not check this; a payload change before fire means the new payload is used.
- Reset mid-operation: any held result is discarded and never presented. No partial response appears. Arbitration restarts with req0 priority.
- Fairness: with both requesters continuously valid and resp_ready=1, grants alternate strictly 0,1,0,1,...

Test Plan:
1. Post-reset, req0 SRA data=0x8000_0000_0000_0000 shamt=63 word=0 -> req0_ready=1 in the same cycle. Next cycle: resp_valid=1, id=0, data=0xFFFF_FFFF_FFFF_FFFF, err=0.
2. Both requesters held valid (req0 SLL 1<<4, req1 SRL 0x100>>4), resp_ready=1 -> first grant req0, then strict alternation. Responses: id 0 data 0x10, id 1 data 0x10, repeated, one per cycle.
3. Backpressure: result held with resp_ready=0 for 3 cycles -> both readies 0 and resp_data stable. Then raise resp_ready -> a new op fires in that same cycle and the new result appears next cycle without a bubble.
4. Word ops:
   - SLLW data=1 shamt=31 -> 0xFFFF_FFFF_8000_0000.
   - SRLW data=0x0000_0000_8000_0000 shamt=0x20 -> effective shift 0 -> 0xFFFF_FFFF_8000_0000.
   - SRAW data=0x0000_0000_8000_0000 shamt=4 -> 0xFFFF_FFFF_F800_0000.
   - SRLW data=0x8000_0000 shamt=1 -> 0x0000_0000_4000_0000.
5. Illegal op=11 from req1 with data=0x1234 -> resp_id=1, resp_data=0, resp_err=1. The next contended grant goes to req0.
6. Assert rst for 1 cycle while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0 and the dropped result never appears. Then both requesters valid -> first grant req0.
